// File: rtl/i2s_tx_sequencer.sv
// Master-mode I2S transmitter: divides the system clock into ck/lr and shifts out 16-bit L/R pairs.
// Build option: define I2S_TX_UNDERRUN_MUTE_EN to send silence on underrun instead of repeating the last pair.
module i2s_tx_sequencer #(
  parameter int CKDIV = 8,
  parameter int SLOT  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  output logic        ck,
  output logic        lr,
  output logic        d,
  output logic        busy,
  output logic        underrun,
  output logic [1:0]  state_dbg
);
  localparam int FRAME = 2 * SLOT;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (CKDIV > 1) ? $clog2(CKDIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);
  localparam logic [BW-1:0] POS_MSB  = BW'(1);
  localparam logic [BW-1:0] POS_LSB  = BW'(16);
  localparam logic [DW-1:0] DIV_TC   = DW'(CKDIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [BW-1:0] bit_q;
  logic          hold_full;
  logic [15:0]   hold_l, hold_r;
  logic [15:0]   last_l, last_r;
  logic [15:0]   sh_l, sh_r;

  logic          div_tc, wrap, accept, bit_d;
  logic [BW-1:0] b_next, pos;
  logic [15:0]   chan;

  // Handshake: a pair transfers on a rising clock edge where in_valid && in_ready;
  // in_ready is simply "holding register empty", independent of in_valid.
  assign in_ready  = !hold_full;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
  assign accept    = in_valid && !hold_full;

  always_comb begin
    div_tc = (div_q == DIV_TC);
    wrap   = (bit_q == LAST_BIT);
    b_next = wrap ? '0 : bit_q + 1'b1;
    pos    = (b_next >= SLOT_B) ? b_next - SLOT_B : b_next;
    chan   = (b_next < SLOT_B) ? sh_l : sh_r;
    bit_d  = 1'b0;
    // Slot position 0 is the one-bit delay after the lr edge; 1..16 carry MSB..LSB.
    if (pos >= POS_MSB && pos <= POS_LSB) bit_d = chan[4'(5'd16 - pos[4:0])];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= LAST_BIT;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      last_l    <= '0;
      last_r    <= '0;
      sh_l      <= '0;
      sh_r      <= '0;
      ck        <= 1'b0;
      lr        <= 1'b1;
      d         <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept) begin
        hold_full <= 1'b1;
        hold_l    <= in_left;
        hold_r    <= in_right;
      end
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= RUN;
            div_q   <= '0;
            bit_q   <= LAST_BIT;
            ck      <= 1'b0;
          end
        end
        default: begin
          if (state_q == RUN && !enable) state_q <= DRAIN;
          else if (state_q == DRAIN && enable) state_q <= RUN;
          div_q <= div_tc ? '0 : div_q + 1'b1;
          if (div_tc) begin
            if (!ck) begin
              ck <= 1'b1;
            end else if (wrap && !enable) begin
              // Frame finished with no run request: park the bus, no new load.
              state_q <= IDLE;
              ck      <= 1'b0;
              lr      <= 1'b1;
              d       <= 1'b0;
            end else begin
              ck    <= 1'b0;
              bit_q <= b_next;
              lr    <= (b_next >= SLOT_B);
              d     <= bit_d;
              if (wrap) begin
                if (hold_full) begin
                  sh_l      <= hold_l;
                  sh_r      <= hold_r;
                  last_l    <= hold_l;
                  last_r    <= hold_r;
                  hold_full <= 1'b0;
                end else begin
                  underrun <= 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                  sh_l   <= '0;
                  sh_r   <= '0;
                  last_l <= '0;
                  last_r <= '0;
`else
                  sh_l <= last_l;
                  sh_r <= last_r;
`endif
                end
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer: time-based behavioural model, loopback decoder, scoreboard.
module tb_i2s_tx_sequencer;
  localparam int CKDIV  = 2;
  localparam int SLOT   = 32;
  localparam int FRAME  = 2 * SLOT;
  localparam int PERIOD = 2 * CKDIV * FRAME;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        in_ready, ck, lr, d, busy, underrun;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  i2s_tx_sequencer #(.CKDIV(CKDIV), .SLOT(SLOT)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .ck(ck), .lr(lr), .d(d), .busy(busy), .underrun(underrun), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_k counts system cycles since the run started; ck half-period h = m_k / CKDIV.
  bit          m_busy;
  int          m_k;
  logic [31:0] m_hold[$];
  logic [31:0] m_last, m_cur;
  logic        e_ck, e_lr, e_d, e_ur;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_hold.delete(); exp_q.delete();
    m_last = '0; m_cur = '0;
    e_ck = 0; e_lr = 1; e_d = 0; e_ur = 0;
  endtask

  task automatic model_step();
    bit acc;
    int h, b, p;
    logic [15:0] ch;
    acc  = in_valid && (m_hold.size() == 0);
    e_ur = 0;
    if (!m_busy) begin
      if (enable) begin m_busy = 1; m_k = 0; end
    end else begin
      m_k++;
      if (m_k % CKDIV == 0) begin
        h = m_k / CKDIV;
        if (h % 2 == 1) e_ck = 1;
        else begin
          b = (h / 2 - 1) % FRAME;
          e_ck = 0;
          if (b == 0 && !enable) begin
            m_busy = 0; e_lr = 1; e_d = 0;
          end else begin
            if (b == 0) begin
              if (m_hold.size() > 0) begin
                m_cur = m_hold.pop_front(); m_last = m_cur;
              end else begin
                e_ur = 1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                m_cur = '0; m_last = '0;
`else
                m_cur = m_last;
`endif
              end
              exp_q.push_back(m_cur);
            end
            e_lr = (b >= SLOT);
            p  = b % SLOT;
            ch = (b < SLOT) ? m_cur[31:16] : m_cur[15:0];
            e_d = (p >= 1 && p <= 16) ? ch[16 - p] : 1'b0;
          end
        end
      end
    end
    if (acc) m_hold.push_back({in_left, in_right});
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- compare process + loopback decoder (scoreboard) ----------------
  logic        prev_ck, dec_prev_lr;
  int          dec_pos, dec_frames;
  logic [15:0] dec_word, dec_l;
  logic [31:0] dec_last;

  initial begin
    prev_ck = 0; dec_prev_lr = 1; dec_pos = 0; dec_frames = 0;
    dec_word = '0; dec_l = '0; dec_last = '0;
  end

  always @(negedge clock) begin
    check("cmp_ck", ck, e_ck);
    check("cmp_lr", lr, e_lr);
    check("cmp_d", d, e_d);
    check("cmp_busy", busy, m_busy);
    check("cmp_in_ready", in_ready, m_hold.size() == 0);
    check("cmp_underrun", underrun, e_ur);
    if (reset) begin
      prev_ck = 0; dec_prev_lr = 1; dec_pos = 0; dec_word = '0;
    end else begin
      if (ck && !prev_ck) begin
        if (lr != dec_prev_lr) dec_pos = 0;
        else dec_pos++;
        dec_prev_lr = lr;
        if (dec_pos >= 1 && dec_pos <= 16) dec_word = {dec_word[14:0], d};
        if (dec_pos == 16) begin
          if (!lr) dec_l = dec_word;
          else begin
            dec_last = {dec_l, dec_word};
            dec_frames++;
            if (exp_q.size() == 0) check("dec_unexpected_frame", dec_last, 32'hxxxx_xxxx);
            else check("dec_pair", dec_last, exp_q.pop_front());
          end
        end
      end
      prev_ck = ck;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] p);
    int n = 0;
    in_left = p[31:16]; in_right = p[15:0]; in_valid = 1;
    while (!in_ready && n < 2 * PERIOD) begin @(posedge clock); #1; n++; end
    check("offer_timeout", n < 2 * PERIOD, 1);
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (!(m_busy && (m_k % PERIOD) == ph) && n < PERIOD + 20) begin
      @(posedge clock); #1; n++;
    end
    check("wait_phase_timeout", n < PERIOD + 20, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 2 * PERIOD) begin @(posedge clock); #1; n++; end
    check("wait_idle_timeout", n < 2 * PERIOD, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rp, rp2, rp3, rp4, rp5;
    int frames_before, n;

    cycles(3);
    reset = 0;
    check("rst_ck", ck, 0);
    check("rst_lr", lr, 1);
    check("rst_d", d, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_underrun", underrun, 0);

    cycles(200);
    check("idle_busy", busy, 0);
    check("idle_lr", lr, 1);

    // First frame: A55A / 1234, start-up latency
    offer(32'hA55A_1234);
    check("idle_accept", in_ready, 0);
    enable = 1;
    cycles(1); check("start_c1_ck", ck, 0); check("start_busy", busy, 1);
    cycles(1); check("start_c2_ck_pre", ck, 0);
    cycles(1); check("first_rise", ck, 1);
    cycles(1); check("first_rise_hold", ck, 1);
    cycles(1); check("first_fall", ck, 0); check("first_fall_lr", lr, 0);
    check("load_frees_hold", in_ready, 1); check("first_no_underrun", underrun, 0);

    // No new pair: underrun at the second frame's start
    n = 0;
    while (!underrun && n < 2 * PERIOD) begin cycles(1); n++; end
    check("second_frame_underrun", underrun, 1);
    check("underrun_lr", lr, 0);
    check("frame1_decoded", dec_last, 32'hA55A_1234);
    cycles(PERIOD - 8);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    check("frame2_mute", dec_last, 32'h0000_0000);
`else
    check("frame2_repeat", dec_last, 32'hA55A_1234);
`endif

    // Offer exactly on the b=0 shift cycle with holding empty
    rp = $urandom;
    wait_phase(2 * CKDIV - 1);
    in_left = rp[31:16]; in_right = rp[15:0]; in_valid = 1;
    cycles(1);
    in_valid = 0;
    check("simul_underrun", underrun, 1);
    check("simul_accepted", in_ready, 0);
    wait_phase(2 * CKDIV - 1);
    check("ready_low_until_load", in_ready, 0);
    cycles(1);
    check("ready_after_load", in_ready, 1);
    check("no_underrun_on_load", underrun, 0);
    cycles(PERIOD - 8);
    check("simul_pair_sent", dec_last, rp);

    // Drop enable mid-left slot: the frame completes, then the bus parks
    wait_phase(2 * CKDIV * 9 + 1);
    frames_before = dec_frames;
    enable = 0;
    wait_idle();
    check("drain_busy", busy, 0);
    check("drain_ck", ck, 0);
    check("drain_lr", lr, 1);
    check("drain_frame_done", dec_frames, frames_before + 1);
    cycles(30);
    check("drain_quiet_ck", ck, 0);

    // Re-enable restarts at b=0
    rp2 = $urandom;
    offer(rp2);
    enable = 1;
    cycles(PERIOD);
    check("restart_pair", dec_last, rp2);

    // Reset during the right slot, with a pair waiting in holding
    rp3 = $urandom;
    offer(rp3);
    wait_phase(2 * CKDIV * (SLOT + 6) + 1);
    rp4 = $urandom;
    offer(rp4);
    #2;
    reset = 1;
    #1;
    check("arst_ck", ck, 0);
    check("arst_lr", lr, 1);
    check("arst_d", d, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_underrun", underrun, 0);
    enable = 0;
    cycles(3);
    reset = 0;
    rp5 = $urandom;
    offer(rp5);
    enable = 1;
    cycles(PERIOD);
    check("post_reset_pair", dec_last, rp5);

    // Randomized traffic and enable toggling
    for (int i = 0; i < 6000; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      if ($urandom_range(0, 499) == 0) enable = ~enable;
      cycles(1);
    end
    in_valid = 0;
    enable = 0;
    wait_idle();
    cycles(10);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
